// File: rtl/triad_uart_arbiter_if.sv
// Triad-array and serial_transmitter signals seen by triad_uart_arbiter.
// master = arbiter side, slave = the triads plus the UART.
interface triad_uart_arbiter_if #(
  parameter int N_TRIADS = 4,
  parameter int FRAME_W  = 102
);
  logic [N_TRIADS-1:0]         data_avl_in;
  logic [N_TRIADS*FRAME_W-1:0] sensor_iterations_in;
  logic [N_TRIADS-1:0]         reset_parser_out;
  logic                        uart_data_avl;
  logic [FRAME_W-1:0]          uart_sensor_iterations;
  logic                        uart_reset_parser;

  modport master (
    input  data_avl_in, sensor_iterations_in, uart_reset_parser,
    output reset_parser_out, uart_data_avl, uart_sensor_iterations
  );

  modport slave (
    output data_avl_in, sensor_iterations_in, uart_reset_parser,
    input  reset_parser_out, uart_data_avl, uart_sensor_iterations
  );
endinterface

// File: rtl/triad_uart_arbiter.sv
// Round-robin share of one serial_transmitter among N_TRIADS triads; frame snapshotted on grant.
// Grant 1 cycle after synced request (3 from data_avl_in); triads hold levels, so waiting costs nothing.
module triad_uart_arbiter #(
  parameter int N_TRIADS = 4,
  parameter int FRAME_W  = 102,
  parameter int TIMEOUT  = 65535,
  parameter int ID_W     = 3
) (
  input  logic                 clk_12MHz,
  input  logic                 rst_n,
  triad_uart_arbiter_if.master bus,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic [7:0]           timeout_count
);

  // Timer serves both the GRANT timeout and the 8-cycle RELEASE window.
  localparam int TW = ($clog2(TIMEOUT + 1) < 3) ? 3 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t              state;
  logic [N_TRIADS-1:0] req_meta;
  logic [N_TRIADS-1:0] req_s;
  logic [ID_W-1:0]     rr_last;
  logic [ID_W-1:0]     pick;
  logic                pick_vld;
  logic [TW-1:0]       timer;
  logic [FRAME_W-1:0]  frame_sel;
  logic                granted_req;
  int                  scan_idx;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = 0;
    for (int k = 1; k <= N_TRIADS; k++) begin
      scan_idx = (int'(rr_last) + k) % N_TRIADS;
      if (!pick_vld && ((req_s & (N_TRIADS'(1) << scan_idx)) != '0)) begin
        pick_vld = 1'b1;
        pick     = ID_W'(scan_idx);
      end
    end
  end

  assign frame_sel   = FRAME_W'(bus.sensor_iterations_in >> (int'(pick) * FRAME_W));
  assign granted_req = (req_s & (N_TRIADS'(1) << grant_id)) != '0;

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      state                      <= IDLE;
      req_meta                   <= '0;
      req_s                      <= '0;
      rr_last                    <= ID_W'(N_TRIADS - 1);
      timer                      <= '0;
      grant_id                   <= '0;
      busy                       <= 1'b0;
      timeout_count              <= '0;
      bus.reset_parser_out       <= '0;
      bus.uart_data_avl          <= 1'b0;
      bus.uart_sensor_iterations <= '0;
    end else begin
      req_meta             <= bus.data_avl_in;
      req_s                <= req_meta;
      bus.reset_parser_out <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_id                   <= pick;
            rr_last                    <= pick;
            bus.uart_sensor_iterations <= frame_sel;
            bus.uart_data_avl          <= 1'b1;
            timer                      <= '0;
            busy                       <= 1'b1;
            state                      <= GRANT;
          end
        end
        GRANT: begin
          timer <= timer + TW'(1);
          // A UART ack on the final timeout cycle counts as success.
          if (bus.uart_reset_parser) begin
            bus.reset_parser_out <= N_TRIADS'(1) << grant_id;
            bus.uart_data_avl    <= 1'b0;
            timer                <= '0;
            state                <= RELEASE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            bus.reset_parser_out <= N_TRIADS'(1) << grant_id;
            bus.uart_data_avl    <= 1'b0;
            timer                <= '0;
            if (timeout_count != 8'hFF) begin
              timeout_count <= timeout_count + 8'd1;
            end
            state <= RELEASE;
          end
        end
        RELEASE: begin
          timer <= timer + TW'(1);
          if (!granted_req || timer == TW'(7)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triad_uart_arbiter.sv
// Directed bench for triad_uart_arbiter: grant timing, round-robin, timeout, collision, snapshot, reset.
// TIMEOUT is 64 so a 40-cycle UART ack completes normally while timeouts stay cheap to exercise.
module tb_triad_uart_arbiter;
  localparam int N  = 4;
  localparam int FW = 102;
  localparam int TO = 64;
  localparam int IW = 3;

  logic          clk_12MHz = 1'b0;
  logic          rst_n     = 1'b1;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic [7:0]    timeout_count;
  logic [FW-1:0] frames [N];
  int            checks = 0;
  int            errors = 0;

  triad_uart_arbiter_if #(.N_TRIADS(N), .FRAME_W(FW)) bus ();

  triad_uart_arbiter #(.N_TRIADS(N), .FRAME_W(FW), .TIMEOUT(TO), .ID_W(IW)) dut (
    .clk_12MHz    (clk_12MHz),
    .rst_n        (rst_n),
    .bus          (bus),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_count(timeout_count)
  );

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.sensor_iterations_in[g*FW +: FW] = frames[g];
  end

  always #5 clk_12MHz = ~clk_12MHz;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_12MHz);
  endtask

  task automatic wait_avl(input logic lvl, input int max, output int n);
    n = 0;
    while (bus.uart_data_avl !== lvl && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    int prev;
    bit loop_ok;
    int rr_exp [6];
    logic [FW-1:0] f1;
    logic [FW-1:0] f2;
    rr_exp = '{0, 1, 2, 3, 0, 1};
    f1 = 102'h2A5A5A5A5A123456789ABCDEF0;
    f2 = 102'h1C3C3C3C3C0FEDCBA987654321;
    bus.data_avl_in       = '0;
    bus.uart_reset_parser = 1'b0;
    for (int i = 0; i < N; i++) frames[i] = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_avl", 128'(bus.uart_data_avl), 128'(0));
    chk("rst_rpo", 128'(bus.reset_parser_out), 128'(0));
    chk("rst_frame", 128'(bus.uart_sensor_iterations), 128'(0));
    chk("rst_gid", 128'(grant_id), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_tc", 128'(timeout_count), 128'(0));
    tick(2);
    rst_n = 1'b1;
    tick();

    // Single request on triad 2, UART acks 40 cycles after the grant
    frames[2] = f1;
    bus.data_avl_in[2] = 1'b1;
    tick(2);
    chk("t1_avl_early", 128'(bus.uart_data_avl), 128'(0));
    tick();
    chk("t1_avl_3cyc", 128'(bus.uart_data_avl), 128'(1));
    chk("t1_gid", 128'(grant_id), 128'(2));
    chk("t1_frame", 128'(bus.uart_sensor_iterations), 128'(f1));
    chk("t1_busy", 128'(busy), 128'(1));
    tick(39);
    chk("t1_avl_held", 128'(bus.uart_data_avl), 128'(1));
    bus.uart_reset_parser = 1'b1;
    tick();
    bus.uart_reset_parser = 1'b0;
    chk("t1_rpo", 128'(bus.reset_parser_out), 128'(4'b0100));
    chk("t1_avl_drop", 128'(bus.uart_data_avl), 128'(0));
    bus.data_avl_in[2] = 1'b0;
    tick();
    chk("t1_rpo_once", 128'(bus.reset_parser_out), 128'(0));
    chk("t1_busy_rel", 128'(busy), 128'(1));
    wait_idle(12, n);
    chk("t1_busy_fall", 128'(n < 12), 128'(1));
    chk("t1_tc", 128'(timeout_count), 128'(0));

    // Round-robin with all four requests held
    do_reset();
    bus.data_avl_in = 4'hF;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      wait_avl(1'b1, 40, n);
      chk("t2_wait_grant", 128'(n < 40), 128'(1));
      chk("t2_gid", 128'(grant_id), 128'(rr_exp[k]));
      chk("t2_no_repeat", 128'(int'(grant_id) != prev), 128'(1));
      prev = int'(grant_id);
      tick(4);
      bus.uart_reset_parser = 1'b1;
      tick();
      bus.uart_reset_parser = 1'b0;
      chk("t2_rpo", 128'(bus.reset_parser_out), 128'(4'b0001 << rr_exp[k]));
    end
    bus.data_avl_in = '0;
    do_reset();

    // Timeout on triad 1 with no UART ack
    bus.data_avl_in[1] = 1'b1;
    wait_avl(1'b1, 20, n);
    chk("t3_wait_grant", 128'(n < 20), 128'(1));
    len = 0;
    while (bus.uart_data_avl === 1'b1 && len < 200) begin
      len++;
      tick();
    end
    chk("t3_grant_len", 128'(len), 128'(TO));
    chk("t3_rpo", 128'(bus.reset_parser_out), 128'(4'b0010));
    chk("t3_tc", 128'(timeout_count), 128'(1));

    // Ack lands on the final timeout cycle: one pulse, counter unchanged
    wait_avl(1'b1, 30, n);
    chk("t4_wait_grant", 128'(n < 30), 128'(1));
    tick(TO - 1);
    chk("t4_avl_last", 128'(bus.uart_data_avl), 128'(1));
    bus.uart_reset_parser = 1'b1;
    tick();
    bus.uart_reset_parser = 1'b0;
    chk("t4_rpo", 128'(bus.reset_parser_out), 128'(4'b0010));
    chk("t4_avl_drop", 128'(bus.uart_data_avl), 128'(0));
    chk("t4_tc_same", 128'(timeout_count), 128'(1));
    tick();
    chk("t4_rpo_once", 128'(bus.reset_parser_out), 128'(0));

    // 299 further timeouts: 300 in total saturates at 255
    loop_ok = 1'b1;
    for (int i = 0; i < 299; i++) begin
      wait_avl(1'b1, 30, n);
      if (n >= 30) loop_ok = 1'b0;
      wait_avl(1'b0, TO + 5, n);
      if (n >= TO + 5) loop_ok = 1'b0;
    end
    chk("t3_loop_waits", 128'(loop_ok), 128'(1));
    chk("t3_tc_sat", 128'(timeout_count), 128'(255));
    bus.data_avl_in = '0;
    do_reset();

    // Frame snapshot stays put while the source changes during GRANT
    frames[1] = f1;
    bus.data_avl_in[1] = 1'b1;
    wait_avl(1'b1, 20, n);
    chk("t5_frame_cap", 128'(bus.uart_sensor_iterations), 128'(f1));
    frames[1] = f2;
    tick(3);
    chk("t5_frame_hold", 128'(bus.uart_sensor_iterations), 128'(f1));
    bus.uart_reset_parser = 1'b1;
    tick();
    bus.uart_reset_parser = 1'b0;
    chk("t5_frame_rel", 128'(bus.uart_sensor_iterations), 128'(f1));
    wait_avl(1'b1, 20, n);
    chk("t5_regrant", 128'(n < 20), 128'(1));
    chk("t5_gid", 128'(grant_id), 128'(1));
    chk("t5_frame_new", 128'(bus.uart_sensor_iterations), 128'(f2));
    bus.uart_reset_parser = 1'b1;
    tick();
    bus.uart_reset_parser = 1'b0;
    bus.data_avl_in = '0;
    wait_idle(12, n);
    do_reset();

    // Async reset in the middle of a grant to triad 1
    bus.data_avl_in = 4'b1010;
    wait_avl(1'b1, 20, n);
    chk("t6_gid_first", 128'(grant_id), 128'(1));
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("t6_avl_async", 128'(bus.uart_data_avl), 128'(0));
    chk("t6_busy_async", 128'(busy), 128'(0));
    chk("t6_gid_async", 128'(grant_id), 128'(0));
    chk("t6_rpo_async", 128'(bus.reset_parser_out), 128'(0));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t6_rpo_in_rst", 128'(bus.reset_parser_out), 128'(0));
    end
    rst_n = 1'b1;
    wait_avl(1'b1, 20, n);
    chk("t6_regrant", 128'(n < 20), 128'(1));
    chk("t6_gid_prio0", 128'(grant_id), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
